// File: rtl/if_id_buf_pkg.sv
// Shared constants for the fetch-to-decode buffer.
// Optional feature macro used by if_id_buf: IF_ID_BYPASS_EN.
package if_id_buf_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;
  localparam int unsigned IF_ID_DEPTH     = 4;

  // Reset is active-low in this pipeline.
  localparam logic RST_ENABLE = 1'b0;

  localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

endpackage : if_id_buf_pkg

// File: rtl/if_id_buf_fifo_ptr_ctrl.sv
// Pointer/occupancy control for the IF/ID FIFO: wrap-around pointers,
// count, full/empty, with reset over flush over push/pop priority.
module if_id_buf_fifo_ptr_ctrl
  import if_id_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = IF_ID_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

endmodule : if_id_buf_fifo_ptr_ctrl

// File: rtl/if_id_buf.sv
// Fetch-to-decode FIFO buffer with valid/ready on both sides and flush.
// Define IF_ID_BYPASS_EN for a zero-latency path when the buffer is empty.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = IF_ID_DEPTH,
  parameter  int unsigned AW    = INST_ADDR_BUS_W,
  parameter  int unsigned DW    = INST_BUS_W,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [AW-1:0] if_pc,
  input  logic [DW-1:0] if_inst,
  output logic          if_ready,
  output logic          id_valid,
  output logic [AW-1:0] id_pc,
  output logic [DW-1:0] id_inst,
  input  logic          id_ready,
  input  logic          flush,
  output logic [CW-1:0] count
);

  logic [AW-1:0] mem_pc_q   [DEPTH];
  logic [DW-1:0] mem_inst_q [DEPTH];
  logic          loaded_q, loaded_d;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty;
  logic          bypass_c, push_c, wr_en_c, pop_c;

  always_comb begin
    bypass_c = 1'b0;
`ifdef IF_ID_BYPASS_EN
    bypass_c = empty & id_ready & if_valid & ~flush;
`endif
    push_c   = if_valid & ~full & ~flush;
    wr_en_c  = push_c & ~bypass_c;
    pop_c    = ~empty & id_ready & ~flush;
    loaded_d = loaded_q | wr_en_c;
  end

  if_id_buf_fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_fifo_ptr_ctrl (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en_c),
    .pop   (pop_c),
    .flush (flush),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_pc_q[wr_ptr]   <= if_pc;
      mem_inst_q[wr_ptr] <= if_inst;
    end
  end

  // Head reads ZeroWord after reset until the first entry is written.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) loaded_q <= 1'b0;
    else                   loaded_q <= loaded_d;
  end

  always_comb begin
    if_ready = ~full;
    id_valid = ~empty | bypass_c;
    if (bypass_c) begin
      id_pc   = if_pc;
      id_inst = if_inst;
    end else if (loaded_q) begin
      id_pc   = mem_pc_q[rd_ptr];
      id_inst = mem_inst_q[rd_ptr];
    end else begin
      id_pc   = AW'(ZERO_WORD);
      id_inst = DW'(ZERO_WORD);
    end
  end

endmodule : if_id_buf

// File: tb/tb_if_id_buf.sv
// Scoreboard bench for if_id_buf; the model follows IF_ID_BYPASS_EN too.
module tb_if_id_buf;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  logic          if_ready;
  logic          id_valid;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic          id_ready;
  logic          flush;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  if_id_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .if_valid(if_valid),
    .if_pc   (if_pc),
    .if_inst (if_inst),
    .if_ready(if_ready),
    .id_valid(id_valid),
    .id_pc   (id_pc),
    .id_inst (id_inst),
    .id_ready(id_ready),
    .flush   (flush),
    .count   (count)
  );

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] exp_pc_q   [$];
  logic [DW-1:0] exp_inst_q [$];
  bit            zero_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Hold rst low for n edges, then confirm the cleared state.
  task automatic do_reset(input int n);
    rst      = 1'b0;
    if_valid = 1'b1;
    if_pc    = '0;
    if_inst  = inst_of('0);
    id_ready = 1'b0;
    flush    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    exp_pc_q.delete();
    exp_inst_q.delete();
    zero_out = 1'b1;
    check("rst_id_valid", id_valid, 0);
    check("rst_if_ready", if_ready, 1);
    check("rst_count",    count,    0);
    check("rst_id_pc",    id_pc,    0);
    check("rst_id_inst",  id_inst,  0);
    rst = 1'b1;
  endtask

  // One cycle: drive, check outputs at negedge, advance the model, cross posedge.
  task automatic step(input logic v, input logic [AW-1:0] pc, input logic idr,
                      input logic fl, output logic acc);
    int sz;
    bit byp;
    logic [AW-1:0] hp;
    logic [DW-1:0] hi;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    id_ready = idr;
    flush    = fl;
    @(negedge clk);
    sz  = exp_pc_q.size();
    byp = 1'b0;
`ifdef IF_ID_BYPASS_EN
    byp = (sz == 0) && idr && v && !fl;
`endif
    check("id_valid", id_valid, (sz != 0) || byp);
    check("if_ready", if_ready, sz < int'(DEPTH));
    check("count",    count,    sz);
    if (byp) begin
      check("byp_pc",   id_pc,   pc);
      check("byp_inst", id_inst, inst_of(pc));
    end else if (sz != 0) begin
      hp = exp_pc_q[0];
      hi = exp_inst_q[0];
      check("head_pc",   id_pc,   hp);
      check("head_inst", id_inst, hi);
    end else if (zero_out) begin
      check("zero_pc", id_pc, 0);
    end
    acc = v && (sz < int'(DEPTH)) && !fl;
    if (fl) begin
      exp_pc_q.delete();
      exp_inst_q.delete();
    end else begin
      if (sz != 0 && idr) begin
        void'(exp_pc_q.pop_front());
        void'(exp_inst_q.pop_front());
      end
      if (acc && !byp) begin
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(inst_of(pc));
        zero_out = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          acc;
    logic [AW-1:0] pc;
    logic          v, idr, fl;

    do_reset(2);

    // Streaming with ID always ready.
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i * 4), 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Stall until full, fifth pair held by fetch.
    pc = 32'h100;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pc, 1'b0, 1'b0, acc);
      if (acc) pc = pc + 32'd4;
    end
    check("full_count", count, DEPTH);
    check("full_ready", if_ready, 0);
    for (int i = 0; i < 8; i++) begin
      step(pc <= 32'h110, pc, 1'b1, 1'b0, acc);
      if (acc) pc = pc + 32'd4;
    end

    // Wrap-around at occupancy 2.
    step(1'b1, 32'h500, 1'b0, 1'b0, acc);
    step(1'b1, 32'h504, 1'b0, 1'b0, acc);
    pc = 32'h508;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, pc, 1'b1, 1'b0, acc);
      pc = pc + 32'd4;
    end
    check("wrap_count", count, 2);

    // Flush at occupancy 3 drops the concurrent push.
    step(1'b1, pc, 1'b0, 1'b0, acc);
    check("pre_flush_count", count, 3);
    step(1'b1, 32'h200, 1'b1, 1'b1, acc);
    check("post_flush_count", count, 0);
    check("post_flush_valid", id_valid, 0);
    step(1'b1, 32'h300, 1'b0, 1'b0, acc);
    check("after_flush_pc", id_pc, 32'h300);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Empty with ID ready: zero-latency when bypass is built in.
    step(1'b1, 32'h40, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Reset mid-operation discards entries.
    step(1'b1, 32'h600, 1'b0, 1'b0, acc);
    step(1'b1, 32'h604, 1'b0, 1'b0, acc);
    do_reset(1);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Randomised traffic; fetch holds a pair until it is accepted.
    pc = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      v   = $urandom_range(0, 3) != 0;
      idr = $urandom_range(0, 2) != 0;
      fl  = $urandom_range(0, 24) == 0;
      step(v, pc, idr, fl, acc);
      if (acc || fl) pc = pc + 32'd4;
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_if_id_buf
